// File: rtl/bist_session_sched_if.sv
// Handshake and status bundle between a scan-BIST session scheduler and its controller.
// The scheduler takes the slave side; the session controller or bench takes the master side.
interface bist_session_sched_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             bist_start;
    logic             bist_abort;
    logic             sig_match;
    logic             scan_en;
    logic             test_sel;
    logic             lfsr_seed;
    logic             misr_clr;
    logic             finish;
    logic             running;
    logic             bist_end;
    logic             pass_fail;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        output bist_start, bist_abort, sig_match,
        input  scan_en, test_sel, lfsr_seed, misr_clr, finish, running, bist_end, pass_fail,
        input  pattern_cnt
    );

    modport slave (
        input  bist_start, bist_abort, sig_match,
        output scan_en, test_sel, lfsr_seed, misr_clr, finish, running, bist_end, pass_fail,
        output pattern_cnt
    );
endinterface

// File: rtl/bist_session_sched.sv
// Scan-BIST session scheduler: seed, counted shift/capture patterns, flush, compare, done.
// Outputs are a Moore decode of the state register plus registered counters and verdict.
module bist_session_sched #(
    parameter int unsigned CHAIN_LEN  = 21,
    parameter int unsigned N_PATTERNS = 100,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    bist_session_sched_if.slave    bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StShift,
        StCapture,
        StFlush,
        StCompare,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] ShiftLast = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PatTotal  = CNT_W'(N_PATTERNS);

    state_e           r_state;
    state_e           w_state_d;
    logic             r_start_q;
    logic [CNT_W-1:0] r_shift_cnt;
    logic [CNT_W-1:0] r_pattern_cnt;
    logic             r_pass_fail;

    logic             w_start_edge;
    logic             w_active;
    logic             w_abort;
    logic             w_shift_last;
    logic [CNT_W-1:0] w_pat_inc;

    logic w_scan_en, w_test_sel, w_lfsr_seed, w_misr_clr, w_finish, w_running, w_bist_end;

    assign w_start_edge = bus.bist_start & ~r_start_q;
    assign w_active     = (r_state inside {StSeed, StShift, StCapture, StFlush, StCompare});
    assign w_abort      = bus.bist_abort & w_active;
    assign w_shift_last = (r_shift_cnt == ShiftLast);
    assign w_pat_inc    = r_pattern_cnt + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_start_edge) w_state_d = StSeed;
            StSeed:    w_state_d = StShift;
            StShift:   if (w_shift_last) w_state_d = StCapture;
            StCapture: w_state_d = (w_pat_inc == PatTotal) ? StFlush : StShift;
            StFlush:   if (w_shift_last) w_state_d = StCompare;
            StCompare: w_state_d = StDone;
            StDone:    if (w_start_edge) w_state_d = StSeed;
            default:   w_state_d = StIdle;
        endcase
        // Abort only exists in the active states, so a start edge in DONE still wins.
        if (w_abort) w_state_d = StDone;
    end

    always_comb begin
        w_scan_en   = 1'b0;
        w_test_sel  = 1'b0;
        w_lfsr_seed = 1'b0;
        w_misr_clr  = 1'b0;
        w_finish    = 1'b0;
        w_running   = 1'b0;
        w_bist_end  = 1'b0;
        unique case (r_state)
            StSeed: begin
                w_lfsr_seed = 1'b1;
                w_misr_clr  = 1'b1;
                w_test_sel  = 1'b1;
                w_running   = 1'b1;
            end
            StShift, StFlush: begin
                w_scan_en  = 1'b1;
                w_test_sel = 1'b1;
                w_running  = 1'b1;
            end
            StCapture: begin
                w_test_sel = 1'b1;
                w_running  = 1'b1;
            end
            StCompare: begin
                w_finish  = 1'b1;
                w_running = 1'b1;
            end
            StDone:  w_bist_end = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_start_q     <= 1'b0;
            r_shift_cnt   <= '0;
            r_pattern_cnt <= '0;
            r_pass_fail   <= 1'b0;
        end else begin
            r_start_q <= bus.bist_start;
            if (w_state_d == StSeed) begin
                // Clearing on entry makes the SEED cycle already show a fresh session.
                r_shift_cnt   <= '0;
                r_pattern_cnt <= '0;
                r_pass_fail   <= 1'b0;
            end else begin
                case (r_state)
                    StShift, StFlush: begin
                        if (!w_abort) r_shift_cnt <= w_shift_last ? '0 : r_shift_cnt + 1'b1;
                    end
                    StCapture: begin
                        if (!w_abort) r_pattern_cnt <= w_pat_inc;
                    end
                    StCompare: r_pass_fail <= w_abort ? 1'b0 : bus.sig_match;
                    default: ;
                endcase
            end
        end
    end

    assign bus.scan_en     = w_scan_en;
    assign bus.test_sel    = w_test_sel;
    assign bus.lfsr_seed   = w_lfsr_seed;
    assign bus.misr_clr    = w_misr_clr;
    assign bus.finish      = w_finish;
    assign bus.running     = w_running;
    assign bus.bist_end    = w_bist_end;
    assign bus.pass_fail   = r_pass_fail;
    assign bus.pattern_cnt = r_pattern_cnt;

endmodule

// File: tb/tb_bist_session_sched.sv
// Directed bench for bist_session_sched with CHAIN_LEN=4, N_PATTERNS=3: a per-cycle vector
// table for whole sessions, aborts and restarts, plus a hand sequence for reset mid-flush.
module tb_bist_session_sched;

    localparam int unsigned CL = 4;
    localparam int unsigned NP = 3;
    localparam int unsigned CW = 16;

    // Expected flags: {scan_en, test_sel, lfsr_seed, misr_clr, finish, running, bist_end, pass_fail}
    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_SEED  = 8'b0111_0100;
    localparam logic [7:0] O_SHIFT = 8'b1100_0100;
    localparam logic [7:0] O_CAP   = 8'b0100_0100;
    localparam logic [7:0] O_FLUSH = 8'b1100_0100;
    localparam logic [7:0] O_CMP   = 8'b0000_1100;
    localparam logic [7:0] O_DONEP = 8'b0000_0011;
    localparam logic [7:0] O_DONEF = 8'b0000_0010;

    typedef struct {
        logic          start;
        logic          abort;
        logic          sm;
        logic [7:0]    exp_o;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    bist_session_sched_if #(.CNT_W(CW)) bus ();

    bist_session_sched #(
        .CHAIN_LEN  (CL),
        .N_PATTERNS (NP),
        .CNT_W      (CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic push(input logic s, input logic a, input logic m, input logic [7:0] o,
                        input int c);
        vec_t v;
        v.start   = s;
        v.abort   = a;
        v.sm      = m;
        v.exp_o   = o;
        v.exp_cnt = CW'(c);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] exp_o, input logic [CW-1:0] exp_c);
        logic [7:0] act;
        act = {bus.scan_en, bus.test_sel, bus.lfsr_seed, bus.misr_clr, bus.finish, bus.running,
               bus.bist_end, bus.pass_fail};
        n_vec++;
        if (act !== exp_o || bus.pattern_cnt !== exp_c) begin
            n_err++;
            $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d", name, act,
                     bus.pattern_cnt, exp_o, exp_c);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic m);
        bus.bist_start = s;
        bus.bist_abort = a;
        bus.sig_match  = m;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);

        // Session 1 (start held high throughout, signature matches).
        push(1, 0, 1, O_SEED, 0);
        for (int p = 0; p < 3; p++) begin
            repeat (4) push(1, 0, 1, O_SHIFT, p);
            push(1, 0, 1, O_CAP, p);
        end
        repeat (4) push(1, 0, 1, O_FLUSH, 3);
        push(1, 0, 0, O_CMP, 3);
        push(1, 0, 1, O_DONEP, 3);      // sig_match=1 sampled at end of COMPARE
        push(1, 0, 0, O_DONEP, 3);      // held start, toggled sig_match: no change
        push(1, 0, 1, O_DONEP, 3);
        push(0, 0, 0, O_DONEP, 3);
        push(1, 0, 0, O_SEED, 0);       // new edge restarts, verdict and count cleared
        // Session 2: stray start edge during SHIFT, signature mismatch.
        push(0, 0, 0, O_SHIFT, 0);
        push(1, 0, 0, O_SHIFT, 0);
        push(1, 0, 0, O_SHIFT, 0);
        push(1, 0, 0, O_SHIFT, 0);
        push(1, 0, 0, O_CAP, 0);
        for (int p = 1; p < 3; p++) begin
            repeat (4) push(1, 0, 0, O_SHIFT, p);
            push(1, 0, 0, O_CAP, p);
        end
        repeat (4) push(1, 0, 0, O_FLUSH, 3);
        push(1, 0, 1, O_CMP, 3);
        push(1, 0, 0, O_DONEF, 3);
        // Session 3: abort on 2nd SHIFT cycle of pattern 2.
        push(0, 0, 0, O_DONEF, 3);
        push(1, 0, 1, O_SEED, 0);
        repeat (4) push(1, 0, 1, O_SHIFT, 0);
        push(1, 0, 1, O_CAP, 0);
        push(1, 0, 1, O_SHIFT, 1);
        push(1, 0, 1, O_SHIFT, 1);
        push(1, 1, 1, O_DONEF, 1);
        push(1, 1, 1, O_DONEF, 1);      // abort ignored in DONE
        // Start edge and abort together in DONE: start wins; then abort in SEED.
        push(0, 0, 0, O_DONEF, 1);
        push(1, 1, 1, O_SEED, 0);
        push(1, 1, 1, O_DONEF, 0);
        push(1, 0, 1, O_DONEF, 0);

        #2;
        check("reset", O_IDLE, '0);
        @(negedge CLK);
        check("reset_held", O_IDLE, '0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_no_start", O_IDLE, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].start, vecs[i].abort, vecs[i].sm);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_cnt);
        end

        // Asynchronous reset during FLUSH.
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("rst_seq_seed", O_SEED, '0);
        repeat (16) @(posedge CLK);
        #1;
        check("rst_seq_flush", O_FLUSH, CW'(3));
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_clear", O_IDLE, '0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            check("rst_idle_after", O_IDLE, '0);
        end
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("rst_restart_seed", O_SEED, '0);
        @(posedge CLK);
        #1;
        check("rst_restart_shift", O_SHIFT, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
